// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Keeps the PC, fetches one word at a time from a request/grant instruction
// memory, and feeds the ID input register. A one-entry skid buffer parks a
// word that returns during a stall. A branch redirect drops any in-flight word.
//
// Handshake: imem_req stays high with imem_addr held constant until a cycle
// in which imem_gnt=1; that edge accepts the request, and it is never withdrawn.
// At most one request is outstanding. Its data returns with imem_rvalid=1 at
// least one cycle after the grant. imem_rvalid is ignored unless a request is
// outstanding (WAIT).
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic [3:0]  IF_ins_type,
  output logic [3:0]  IF_ins_number,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] addr_q, addr_n;
  logic        discard, discard_n;
  logic [31:0] skid_inst, skid_inst_n;
  logic [31:0] skid_pc4, skid_pc4_n;
  logic        skid_full, skid_full_n;
  logic [31:0] inst_n, pc4_n;
  logic        valid_n;
  logic [3:0]  type_n, num_n;
  logic [3:0]  cnt, cnt_n;
  logic        resp, keep;

  // Map an opcode to its debug instruction class.
  function automatic logic [3:0] decode_type(input logic [5:0] op);
    logic [3:0] t;
    t = 4'd15;
    if (op == 6'h00)                        t = 4'd1;
    else if (op >= 6'h08 && op <= 6'h0F)    t = 4'd2;
    else if (op == 6'h23)                   t = 4'd3;
    else if (op == 6'h2B)                   t = 4'd4;
    else if (op == 6'h04 || op == 6'h05)    t = 4'd5;
    else if (op == 6'h02 || op == 6'h03)    t = 4'd6;
    return t;
  endfunction

  assign resp      = (state == WAIT) && imem_rvalid;
  assign keep      = resp && !discard;
  assign imem_req  = (state == REQ);
  assign imem_addr = addr_q;
  assign fsm_state = state;

  // Next-state, PC, skid and output-register logic; redirect beats stall.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    addr_n      = addr_q;
    discard_n   = discard;
    skid_inst_n = skid_inst;
    skid_pc4_n  = skid_pc4;
    skid_full_n = skid_full;
    inst_n      = if_inst;
    pc4_n       = if_pc4;
    valid_n     = if_valid;
    type_n      = IF_ins_type;
    num_n       = IF_ins_number;
    cnt_n       = cnt;

    if (branch_taken) begin
      pc_n        = branch_target;
      skid_full_n = 1'b0;
      inst_n      = 32'h0;
      valid_n     = 1'b0;
      type_n      = 4'd0;
      // A pending or granted request will still return a stale word,
      // unless it is returning right now (then it is simply not used).
      discard_n   = (state == REQ) || ((state == WAIT) && !imem_rvalid);
    end else begin
      if (resp && discard) discard_n = 1'b0;
      // After a redirect, pc already holds the new target, so a late grant
      // of the old request must not advance it.
      if ((state == REQ) && imem_gnt && !discard) pc_n = pc + 32'd4;
      if (!stall) begin
        if (skid_full) begin
          inst_n      = skid_inst;
          pc4_n       = skid_pc4;
          valid_n     = 1'b1;
          type_n      = decode_type(skid_inst[31:26]);
          num_n       = cnt;
          cnt_n       = cnt + 4'd1;
          skid_full_n = 1'b0;
        end else if (keep) begin
          inst_n  = imem_rdata;
          pc4_n   = addr_q + 32'd4;
          valid_n = 1'b1;
          type_n  = decode_type(imem_rdata[31:26]);
          num_n   = cnt;
          cnt_n   = cnt + 4'd1;
        end else begin
          inst_n  = 32'h0;
          valid_n = 1'b0;
          type_n  = 4'd0;
        end
      end else if (keep) begin
        skid_inst_n = imem_rdata;
        skid_pc4_n  = addr_q + 32'd4;
        skid_full_n = 1'b1;
      end
    end

    case (state)
      IDLE:    if (!skid_full_n) state_n = REQ;
      REQ:     if (imem_gnt) state_n = WAIT;
      WAIT:    if (imem_rvalid) state_n = skid_full_n ? IDLE : REQ;
      default: state_n = IDLE;
    endcase

    // Address is captured once per request so it cannot move before grant.
    if ((state_n == REQ) && (state != REQ)) addr_n = pc_n;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Datapath registers: PC, request address, discard, skid and ID outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc            <= RESET_PC;
      addr_q        <= RESET_PC;
      discard       <= 1'b0;
      skid_inst     <= 32'h0;
      skid_pc4      <= 32'h0;
      skid_full     <= 1'b0;
      if_inst       <= 32'h0;
      if_pc4        <= 32'h0;
      if_valid      <= 1'b0;
      IF_ins_type   <= 4'd0;
      IF_ins_number <= 4'd0;
      cnt           <= 4'd0;
    end else begin
      pc            <= pc_n;
      addr_q        <= addr_n;
      discard       <= discard_n;
      skid_inst     <= skid_inst_n;
      skid_pc4      <= skid_pc4_n;
      skid_full     <= skid_full_n;
      if_inst       <= inst_n;
      if_pc4        <= pc4_n;
      if_valid      <= valid_n;
      IF_ins_type   <= type_n;
      IF_ins_number <= num_n;
      cnt           <= cnt_n;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: memory responder, output collector, one task per
// scenario, and a behavioural model of the expected instruction stream.
module tb_if_stage;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic [3:0]  IF_ins_type;
  logic [3:0]  IF_ins_number;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  if_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_inst(if_inst), .if_pc4(if_pc4), .if_valid(if_valid),
    .IF_ins_type(IF_ins_type), .IF_ins_number(IF_ins_number),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory contents and reference model ----------------
  logic [31:0] mem_salt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [2:0] k;
    logic [5:0] op;
    if (a == RPC) return 32'h0000_0020;
    k = a[4:2] ^ a[7:5] ^ mem_salt[2:0];
    case (k)
      3'd0: op = 6'h00;
      3'd1: op = 6'h08;
      3'd2: op = 6'h0F;
      3'd3: op = 6'h23;
      3'd4: op = 6'h2B;
      3'd5: op = 6'h05;
      3'd6: op = 6'h02;
      default: op = 6'h3F;
    endcase
    return {op, a[27:2] ^ mem_salt[31:6]};
  endfunction

  function automatic logic [3:0] ref_type(input logic [31:0] w);
    int op;
    op = int'(w[31:26]);
    if (op == 0) return 4'd1;
    if (op >= 8 && op <= 15) return 4'd2;
    if (op == 35) return 4'd3;
    if (op == 43) return 4'd4;
    if (op == 4 || op == 5) return 4'd5;
    if (op == 2 || op == 3) return 4'd6;
    return 4'd15;
  endfunction

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc4_q[$];

  // Sequential fetch from address a, k words, wrapping mod 2^32.
  function automatic void build_exp(input logic [31:0] a, input int k);
    logic [31:0] fa;
    exp_q.delete();
    exp_pc4_q.delete();
    for (int i = 0; i < k; i++) begin
      fa = a + 32'(4 * i);
      exp_q.push_back(mem_word(fa));
      exp_pc4_q.push_back(fa + 32'd4);
    end
  endfunction

  // ---------------- memory responder ----------------
  int          gnt_delay = 0;
  int          rv_delay  = 1;
  int          waitc     = 0;
  int          resp_cnt  = 0;
  int          addr_unstable = 0;
  logic [31:0] resp_addr;
  logic [31:0] held_addr;
  logic [31:0] gnt_addr_q[$];

  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    resp_addr   = 32'h0;
    held_addr   = 32'h0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(resp_addr);
        end
      end
      imem_gnt = 1'b0;
      if (imem_req && rst) begin
        if (waitc > 0 && imem_addr !== held_addr) addr_unstable++;
        if (waitc == 0) held_addr = imem_addr;
        if (waitc >= gnt_delay) begin
          imem_gnt  = 1'b1;
          resp_addr = imem_addr;
          resp_cnt  = rv_delay;
          gnt_addr_q.push_back(imem_addr);
          waitc     = 0;
        end else begin
          waitc++;
        end
      end else begin
        waitc = 0;
      end
    end
  end

  // ---------------- output collector ----------------
  logic        st_e = 1'b0;
  logic        br_e = 1'b0;
  int          seq = 0;
  int          freeze_viol = 0;
  logic [72:0] prev_b = '0;
  logic [31:0] obs_inst[$];
  logic [31:0] obs_pc4[$];
  logic [3:0]  obs_type[$];
  logic [3:0]  obs_num[$];
  logic [3:0]  obs_seq[$];

  always @(posedge clk) begin
    st_e <= stall;
    br_e <= branch_taken;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        seq = 0;
      end else begin
        if (st_e && !br_e &&
            {if_inst, if_pc4, if_valid, IF_ins_type, IF_ins_number} !== prev_b)
          freeze_viol++;
        if (!st_e && if_valid) begin
          obs_inst.push_back(if_inst);
          obs_pc4.push_back(if_pc4);
          obs_type.push_back(IF_ins_type);
          obs_num.push_back(IF_ins_number);
          obs_seq.push_back(4'(seq));
          seq++;
        end
      end
      prev_b = {if_inst, if_pc4, if_valid, IF_ins_type, IF_ins_number};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_inst.delete();
    obs_pc4.delete();
    obs_type.delete();
    obs_num.delete();
    obs_seq.delete();
  endtask

  task automatic redirect(input logic [31:0] a);
    branch_taken  = 1'b1;
    branch_target = a;
    step();
    branch_taken  = 1'b0;
    clear_obs();
  endtask

  task automatic wait_words(input int k, output bit to);
    for (int c = 0; c < 3000 && obs_inst.size() < k; c++) step();
    to = (obs_inst.size() < k);
  endtask

  task automatic wait_wait_state(output bit to);
    for (int c = 0; c < 200 && fsm_state != 2'd2; c++) step();
    to = (fsm_state != 2'd2);
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    repeat (3) step();
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== RPC) begin
      n_fail++;
      $display("FAIL reset_req: got req=%b addr=%h, want req=0 addr=%h", imem_req, imem_addr, RPC);
    end
    n_checks++;
    if (if_inst !== 32'h0 || if_pc4 !== 32'h0 || if_valid !== 1'b0 ||
        IF_ins_type !== 4'd0 || IF_ins_number !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_out: got inst=%h pc4=%h v=%b type=%0d num=%0d, want all zero",
               if_inst, if_pc4, if_valid, IF_ins_type, IF_ins_number);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      n_fail++;
      $display("FAIL first_req: got req=%b addr=%h, want req=1 addr=%h", imem_req, imem_addr, RPC);
    end
    step();
    n_checks++;
    if (if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_latency: got if_valid=%b one edge early, want 0", if_valid);
    end
    step();
    n_checks++;
    if (if_valid !== 1'b1 || if_inst !== 32'h0000_0020 || if_pc4 !== 32'h0000_0104 ||
        IF_ins_type !== 4'd1 || IF_ins_number !== 4'd0) begin
      n_fail++;
      $display("FAIL first_word: got v=%b inst=%h pc4=%h type=%0d num=%0d, want v=1 inst=00000020 pc4=00000104 type=1 num=0",
               if_valid, if_inst, if_pc4, IF_ins_type, IF_ins_number);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int s0, k;
    gnt_delay = 0;
    rv_delay  = 1;
    redirect(32'h0000_1000);
    wait_words(1, to);
    s0 = obs_inst.size();
    repeat (20) step();
    n_checks++;
    if (to || obs_inst.size() - s0 != 10) begin
      n_fail++;
      $display("FAIL b2b_rate: got %0d words in 20 cycles (timeout=%0d), want 10", obs_inst.size() - s0, to);
    end
    k = obs_inst.size();
    build_exp(32'h0000_1000, k);
    for (int i = 0; i < k; i++) begin
      n_checks++;
      if (obs_inst[i] !== exp_q[i] || obs_pc4[i] !== exp_pc4_q[i] ||
          obs_type[i] !== ref_type(exp_q[i]) || obs_num[i] !== obs_seq[i]) begin
        n_fail++;
        $display("FAIL b2b_stream[%0d]: got inst=%h pc4=%h type=%0d num=%0d, want inst=%h pc4=%h type=%0d num=%0d",
                 i, obs_inst[i], obs_pc4[i], obs_type[i], obs_num[i], exp_q[i], exp_pc4_q[i], ref_type(exp_q[i]), obs_seq[i]);
      end
    end
  endtask

  task automatic test_stall();
    bit to, to2;
    int s0, v0, req_late, k;
    redirect(32'h0000_2000);
    wait_words(2, to);
    wait_wait_state(to2);
    s0 = obs_inst.size();
    v0 = freeze_viol;
    req_late = 0;
    stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (c >= 2 && imem_req) req_late++;
    end
    stall = 1'b0;
    n_checks++;
    if (to || to2 || freeze_viol != v0) begin
      n_fail++;
      $display("FAIL stall_freeze: got %0d output changes while stalled (timeout=%0d/%0d), want 0", freeze_viol - v0, to, to2);
    end
    n_checks++;
    if (req_late != 0) begin
      n_fail++;
      $display("FAIL stall_noreq: got %0d request cycles with word parked, want 0", req_late);
    end
    wait_words(s0 + 4, to);
    k = obs_inst.size();
    build_exp(32'h0000_2000, k);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL stall_resume: got %0d words after release, want at least %0d", k, s0 + 4);
    end
    for (int i = 0; i < k; i++) begin
      n_checks++;
      if (obs_inst[i] !== exp_q[i] || obs_pc4[i] !== exp_pc4_q[i] ||
          obs_type[i] !== ref_type(exp_q[i]) || obs_num[i] !== obs_seq[i]) begin
        n_fail++;
        $display("FAIL stall_stream[%0d]: got inst=%h pc4=%h type=%0d num=%0d, want inst=%h pc4=%h type=%0d num=%0d",
                 i, obs_inst[i], obs_pc4[i], obs_type[i], obs_num[i], exp_q[i], exp_pc4_q[i], ref_type(exp_q[i]), obs_seq[i]);
      end
    end
  endtask

  task automatic test_branch_wait();
    bit to, to2;
    int k;
    rv_delay = 3;
    redirect(32'h0000_3000);
    wait_words(1, to);
    wait_wait_state(to2);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0400;
    gnt_addr_q.delete();
    step();
    branch_taken = 1'b0;
    clear_obs();
    n_checks++;
    if (to || to2 || if_valid !== 1'b0 || if_inst !== 32'h0) begin
      n_fail++;
      $display("FAIL branch_bubble: got v=%b inst=%h (timeout=%0d/%0d), want v=0 inst=0", if_valid, if_inst, to, to2);
    end
    wait_words(3, to);
    n_checks++;
    if (gnt_addr_q.size() == 0 || gnt_addr_q[0] !== 32'h0000_0400) begin
      n_fail++;
      $display("FAIL branch_addr: got first granted addr=%h (n=%0d), want 00000400",
               gnt_addr_q.size() ? gnt_addr_q[0] : 32'hx, gnt_addr_q.size());
    end
    k = to ? obs_inst.size() : 3;
    build_exp(32'h0000_0400, k);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL branch_timeout: got %0d words, want 3", obs_inst.size());
    end
    for (int i = 0; i < k; i++) begin
      n_checks++;
      if (obs_inst[i] !== exp_q[i] || obs_pc4[i] !== exp_pc4_q[i] ||
          obs_type[i] !== ref_type(exp_q[i]) || obs_num[i] !== obs_seq[i]) begin
        n_fail++;
        $display("FAIL branch_stream[%0d]: got inst=%h pc4=%h type=%0d num=%0d, want inst=%h pc4=%h type=%0d num=%0d",
                 i, obs_inst[i], obs_pc4[i], obs_type[i], obs_num[i], exp_q[i], exp_pc4_q[i], ref_type(exp_q[i]), obs_seq[i]);
      end
    end
    rv_delay = 1;
  endtask

  task automatic test_branch_stall();
    bit to, to2;
    int k, held_valid;
    redirect(32'h0000_5000);
    wait_words(1, to);
    wait_wait_state(to2);
    stall = 1'b1;
    step();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0600;
    step();
    branch_taken = 1'b0;
    clear_obs();
    n_checks++;
    if (to || to2 || if_valid !== 1'b0 || if_inst !== 32'h0) begin
      n_fail++;
      $display("FAIL bstall_bubble: got v=%b inst=%h (timeout=%0d/%0d), want v=0 inst=0", if_valid, if_inst, to, to2);
    end
    held_valid = 0;
    repeat (6) begin
      step();
      if (if_valid) held_valid++;
    end
    n_checks++;
    if (held_valid != 0) begin
      n_fail++;
      $display("FAIL bstall_hold: got %0d valid cycles while stalled after redirect, want 0", held_valid);
    end
    stall = 1'b0;
    wait_words(3, to);
    k = to ? obs_inst.size() : 3;
    build_exp(32'h0000_0600, k);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL bstall_timeout: got %0d words, want 3", obs_inst.size());
    end
    for (int i = 0; i < k; i++) begin
      n_checks++;
      if (obs_inst[i] !== exp_q[i] || obs_pc4[i] !== exp_pc4_q[i] ||
          obs_type[i] !== ref_type(exp_q[i]) || obs_num[i] !== obs_seq[i]) begin
        n_fail++;
        $display("FAIL bstall_stream[%0d]: got inst=%h pc4=%h type=%0d num=%0d, want inst=%h pc4=%h type=%0d num=%0d",
                 i, obs_inst[i], obs_pc4[i], obs_type[i], obs_num[i], exp_q[i], exp_pc4_q[i], ref_type(exp_q[i]), obs_seq[i]);
      end
    end
  endtask

  task automatic test_gnt_delay_wrap();
    bit to;
    int au, k;
    gnt_delay = 3;
    redirect(32'hFFFF_FFC0);
    au = addr_unstable;
    wait_words(17, to);
    n_checks++;
    if (addr_unstable != au) begin
      n_fail++;
      $display("FAIL addr_stable: got %0d address changes before grant, want 0", addr_unstable - au);
    end
    n_checks++;
    if (to || obs_pc4[15] !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL pc4_wrap: got pc4=%h for fetch at FFFFFFFC (timeout=%0d), want 00000000",
               to ? 32'hx : obs_pc4[15], to);
    end
    k = to ? obs_inst.size() : 17;
    build_exp(32'hFFFF_FFC0, k);
    for (int i = 0; i < k; i++) begin
      n_checks++;
      if (obs_inst[i] !== exp_q[i] || obs_pc4[i] !== exp_pc4_q[i] ||
          obs_type[i] !== ref_type(exp_q[i]) || obs_num[i] !== obs_seq[i]) begin
        n_fail++;
        $display("FAIL wrap_stream[%0d]: got inst=%h pc4=%h type=%0d num=%0d, want inst=%h pc4=%h type=%0d num=%0d",
                 i, obs_inst[i], obs_pc4[i], obs_type[i], obs_num[i], exp_q[i], exp_pc4_q[i], ref_type(exp_q[i]), obs_seq[i]);
      end
    end
    gnt_delay = 0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    int k, v0, au;
    for (int r = 0; r < 3; r++) begin
      gnt_delay = int'($urandom_range(0, 2));
      rv_delay  = int'($urandom_range(1, 3));
      a = $urandom() & 32'hFFFF_FFFC;
      redirect(a);
      v0 = freeze_viol;
      au = addr_unstable;
      for (int c = 0; c < 80; c++) begin
        stall = ($urandom_range(0, 3) == 0);
        step();
      end
      stall = 1'b0;
      repeat (12) step();
      k = obs_inst.size();
      n_checks++;
      if (k == 0 || freeze_viol != v0 || addr_unstable != au) begin
        n_fail++;
        $display("FAIL rand_sanity[%0d]: got words=%0d freeze_changes=%0d addr_changes=%0d, want words>0 and 0 changes",
                 r, k, freeze_viol - v0, addr_unstable - au);
      end
      build_exp(a, k);
      for (int i = 0; i < k; i++) begin
        n_checks++;
        if (obs_inst[i] !== exp_q[i] || obs_pc4[i] !== exp_pc4_q[i] ||
            obs_type[i] !== ref_type(exp_q[i]) || obs_num[i] !== obs_seq[i]) begin
          n_fail++;
          $display("FAIL rand_stream[%0d][%0d]: got inst=%h pc4=%h type=%0d num=%0d, want inst=%h pc4=%h type=%0d num=%0d",
                   r, i, obs_inst[i], obs_pc4[i], obs_type[i], obs_num[i], exp_q[i], exp_pc4_q[i], ref_type(exp_q[i]), obs_seq[i]);
        end
      end
    end
    gnt_delay = 0;
    rv_delay  = 1;
  endtask

  task automatic test_reset_mid_wait();
    bit to, to2;
    int k;
    rv_delay = 4;
    redirect(32'h0000_7000);
    wait_wait_state(to);
    rst = 1'b0;
    repeat (6) step();
    n_checks++;
    if (to || imem_req !== 1'b0 || imem_addr !== RPC || if_inst !== 32'h0 || if_pc4 !== 32'h0 ||
        if_valid !== 1'b0 || IF_ins_type !== 4'd0 || IF_ins_number !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_out: got req=%b addr=%h inst=%h pc4=%h v=%b type=%0d num=%0d (timeout=%0d), want reset values",
               imem_req, imem_addr, if_inst, if_pc4, if_valid, IF_ins_type, IF_ins_number, to);
    end
    rv_delay = 1;
    gnt_addr_q.delete();
    clear_obs();
    rst = 1'b1;
    wait_words(2, to2);
    n_checks++;
    if (gnt_addr_q.size() == 0 || gnt_addr_q[0] !== RPC) begin
      n_fail++;
      $display("FAIL midreset_addr: got first granted addr=%h (n=%0d), want %h",
               gnt_addr_q.size() ? gnt_addr_q[0] : 32'hx, gnt_addr_q.size(), RPC);
    end
    k = to2 ? obs_inst.size() : 2;
    build_exp(RPC, k);
    n_checks++;
    if (to2 || obs_num[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_num: got first number=%0d (timeout=%0d), want 0", to2 ? 4'hx : obs_num[0], to2);
    end
    for (int i = 0; i < k; i++) begin
      n_checks++;
      if (obs_inst[i] !== exp_q[i] || obs_pc4[i] !== exp_pc4_q[i] ||
          obs_type[i] !== ref_type(exp_q[i]) || obs_num[i] !== obs_seq[i]) begin
        n_fail++;
        $display("FAIL midreset_stream[%0d]: got inst=%h pc4=%h type=%0d num=%0d, want inst=%h pc4=%h type=%0d num=%0d",
                 i, obs_inst[i], obs_pc4[i], obs_type[i], obs_num[i], exp_q[i], exp_pc4_q[i], ref_type(exp_q[i]), obs_seq[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst           = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    mem_salt      = $urandom();
    test_reset();
    test_back_to_back();
    test_stall();
    test_branch_wait();
    test_branch_stall();
    test_gnt_delay_wrap();
    test_random();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
